// File: rtl/pe_qz_defs.sv
// rtl/pe_qz_defs.sv - shared constants, state type and clog2 helper for the lane packer
package pe_qz_defs;

  localparam int PE_QZ_TBYTE = 8;
  localparam int PE_QZ_NLANE = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } pe_qz_state_e;

  function automatic int pe_qz_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_qz_obuf.sv
// rtl/pe_qz_obuf.sv - 2-entry output FIFO with registered head and zeroed empty slots
module pe_qz_obuf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_s_tdata,
  input  logic         i_s_tvalid,
  output logic         o_s_tready,
  output logic [W-1:0] o_m_tdata,
  output logic         o_m_tvalid,
  input  logic         i_m_tready
);

  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         r_vld0;
  logic         r_vld1;
  logic         w_push;
  logic         w_pop;

  // Readiness depends only on stored occupancy, never on the downstream ready.
  assign o_s_tready = ~r_vld1;
  assign o_m_tdata  = r_d0;
  assign o_m_tvalid = r_vld0;
  assign w_push     = i_s_tvalid & ~r_vld1;
  assign w_pop      = r_vld0 & i_m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0   <= '0;
      r_d1   <= '0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (!r_vld0) begin
            r_d0   <= i_s_tdata;
            r_vld0 <= 1'b1;
          end else begin
            r_d1   <= i_s_tdata;
            r_vld1 <= 1'b1;
          end
        end
        2'b01: begin
          if (r_vld1) begin
            r_d0   <= r_d1;
            r_d1   <= '0;
            r_vld1 <= 1'b0;
          end else begin
            r_d0   <= '0;
            r_vld0 <= 1'b0;
          end
        end
        2'b11: r_d0 <= i_s_tdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pe_qz_packer.sv
// rtl/pe_qz_packer.sv - packs TBYTE-wide beats into NLANE-lane words with flush and keep flags
module pe_qz_packer
  import pe_qz_defs::*;
#(
  parameter int TBYTE     = PE_QZ_TBYTE,
  parameter int NLANE     = PE_QZ_NLANE,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TBYTE-1:0]       data8_din,
  input  logic                   valid8_din,
  input  logic                   flush_din,
  output logic                   ready8_dout,
  output logic [TBYTE*NLANE-1:0] data_dout,
  output logic [NLANE-1:0]       keep_dout,
  output logic                   last_dout,
  output logic                   valid_dout,
  input  logic                   ready_din
);

  localparam int CW = pe_qz_clog2(NLANE);
  localparam int DW = TBYTE * NLANE;
  localparam int FW = DW + NLANE + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NLANE - 1);

  pe_qz_state_e   r_state;
  pe_qz_state_e   w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_pack;
  logic [NLANE-1:0] r_keep;
  logic           r_rdy_en;

  logic           w_buf_ready;
  logic           w_accept;
  logic           w_close_beat;
  logic           w_flush_only;
  logic           w_push;
  logic [CW-1:0]  w_lane;
  int             w_base;
  logic [DW-1:0]  w_ins_pack;
  logic [NLANE-1:0] w_ins_keep;
  logic [FW-1:0]  w_push_word;
  logic [FW-1:0]  w_out_word;

  // r_rdy_en holds ready low through reset and up to the first edge after release.
  assign ready8_dout  = r_rdy_en & w_buf_ready;
  assign w_accept     = valid8_din & ready8_dout;
  assign w_close_beat = w_accept & (flush_din | (r_cnt == LAST_LANE));
  assign w_flush_only = flush_din & ~valid8_din & ready8_dout & (r_state == ST_FILL);
  assign w_push       = w_close_beat | w_flush_only;
  assign w_lane       = (MSB_FIRST != 0) ? (LAST_LANE - r_cnt) : r_cnt;

  always_comb begin
    w_base     = int'(w_lane) * TBYTE;
    w_ins_pack = r_pack;
    w_ins_pack[w_base +: TBYTE] = data8_din;
    w_ins_keep = r_keep | (NLANE'(1) << r_cnt);
  end

  assign w_push_word = w_close_beat ? {w_ins_pack, w_ins_keep, flush_din}
                                    : {r_pack, r_keep, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_push)        w_state_nxt = ST_EMPTY;
    else if (w_accept) w_state_nxt = ST_FILL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_pack   <= '0;
      r_keep   <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) begin
        r_cnt  <= '0;
        r_pack <= '0;
        r_keep <= '0;
      end else if (w_accept) begin
        r_cnt  <= r_cnt + 1'b1;
        r_pack <= w_ins_pack;
        r_keep <= w_ins_keep;
      end
    end
  end

  pe_qz_obuf #(
    .W (FW)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (reset),
    .i_s_tdata  (w_push_word),
    .i_s_tvalid (w_push),
    .o_s_tready (w_buf_ready),
    .o_m_tdata  (w_out_word),
    .o_m_tvalid (valid_dout),
    .i_m_tready (ready_din)
  );

  assign {data_dout, keep_dout, last_dout} = w_out_word;

endmodule
